// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU arbiter slice.
package alu_pkg;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_REQ = 2;

    typedef logic [2:0] alu_op_t;

    typedef struct packed {
        logic o;
        logic c;
        logic z;
        logic n;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals around alu_arbiter.
// slave = arbiter view; master = requesters, ALU and response consumer.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    alu_op_t [NUM_REQ-1:0]          req_op;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_b;

    logic [DATA_W-1:0]              alu_a;
    logic [DATA_W-1:0]              alu_b;
    alu_op_t                        alu_op;
    logic [DATA_W-1:0]              alu_y;
    alu_flags_t                     alu_flags;

    logic                           rsp_valid;
    logic                           rsp_ready;
    logic                           rsp_id;
    logic [DATA_W-1:0]              rsp_y;
    alu_flags_t                     rsp_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_y, alu_flags, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_y, rsp_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_y, alu_flags, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_y, rsp_flags
    );
endinterface

// File: rtl/arb_rr_pick.sv
// Combinational two-way picker: round-robin on last-granted ID, or fixed
// priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module arb_rr_pick (
    input  logic [1:0] i_valid,
    input  logic       i_last_id,
    output logic [1:0] o_grant,
    output logic       o_win_id
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic w_unused_last_id;
    assign w_unused_last_id = i_last_id;

    always_comb begin
        o_win_id = 1'b0;
        if (!i_valid[0] && i_valid[1]) begin
            o_win_id = 1'b1;
        end
    end
`else
    always_comb begin
        o_win_id = 1'b0;
        if (&i_valid) begin
            o_win_id = ~i_last_id;
        end else begin
            o_win_id = i_valid[1];
        end
    end
`endif

    always_comb begin
        o_grant = 2'b00;
        if (|i_valid) begin
            o_grant = o_win_id ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared ALU (IDLE -> EXEC -> RESP).
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority to requester 0.
module alu_arbiter
    import alu_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [1:0]        w_grant;
    logic              w_win_id;
    logic              w_last_id;
    logic [1:0]        w_req_ready;
    logic              w_hs;

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    alu_op_t           r_alu_op;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_y;
    alu_flags_t        r_rsp_flags;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_last_id = 1'b1;
`else
    logic r_last_id;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_id <= 1'b1;
        end else if (w_hs) begin
            r_last_id <= w_win_id;
        end
    end

    assign w_last_id = r_last_id;
`endif

    arb_rr_pick u_pick (
        .i_valid  (bus.req_valid),
        .i_last_id(w_last_id),
        .o_grant  (w_grant),
        .o_win_id (w_win_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_hs)          w_state_nxt = ST_EXEC;
            ST_EXEC:                    w_state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 2'b00;
        if (r_state == ST_IDLE) begin
            w_req_ready = w_grant;
        end
    end

    assign w_hs = |(bus.req_valid & w_req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_alu_a  <= bus.req_a[w_win_id];
                        r_alu_b  <= bus.req_b[w_win_id];
                        r_alu_op <= bus.req_op[w_win_id];
                        r_rsp_id <= w_win_id;
                    end
                end
                ST_EXEC: begin
                    r_rsp_y     <= bus.alu_y;
                    r_rsp_flags <= bus.alu_flags;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_flags = r_rsp_flags;
endmodule
